// File: rtl/ysyx_23060236_dcache_wbuf_pkg.sv
// Shared dcache constants: address split, AXI response code and write-back buffer FSM encodings.
package ysyx_23060236_dcache_wbuf_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int DATA_LEN   = 32;
    localparam int OFFSET_LEN = 2;
    localparam int INDEX_LEN  = 4;
    localparam int TAG_LEN    = ADDR_LEN - OFFSET_LEN - INDEX_LEN;
    localparam int WORD_LEN   = ADDR_LEN - OFFSET_LEN;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    localparam logic [1:0] WB_IDLE = 2'd0;
    localparam logic [1:0] WB_SEND = 2'd1;
    localparam logic [1:0] WB_RESP = 2'd2;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060236_wbuf_fifo.sv
// Victim-word queue of the write-back buffer: storage, head/tail/count and the forwarding lookup.
module ysyx_23060236_wbuf_fifo
    import ysyx_23060236_dcache_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push_en,
    input  logic [WORD_LEN-1:0] push_addr,
    input  logic [DATA_LEN-1:0] push_data,
    input  logic                pop_en,
    output logic [WORD_LEN-1:0] head_addr,
    output logic [DATA_LEN-1:0] head_data,
    output logic                full,
    output logic                empty,
    input  logic [WORD_LEN-1:0] fwd_addr,
    output logic                fwd_hit,
    output logic [DATA_LEN-1:0] fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic [WORD_LEN-1:0] addr_mem [DEPTH];
    logic [DATA_LEN-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]    slot;

    // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_en) tail <= tail + 1'b1;
            if (pop_en)  head <= head + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; count alone decides which slots hold live entries.
    always_ff @(posedge clock) begin
        if (push_en) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign full      = count == (PTR_W+1)'(DEPTH);
    assign empty     = count == '0;
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    // Walk oldest to youngest so the youngest matching entry is the one left standing.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if ((PTR_W+1)'(k) < count && addr_mem[slot] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[slot];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060236_dcache_wbuf.sv
// Dcache write-back buffer: queues dirty victims and drains them over AXI4-Lite AW/W/B.
// Define YSYX_23060236_WBUF_ERR_EN to record non-OKAY write responses in a sticky wb_err flag.
module ysyx_23060236_dcache_wbuf
    import ysyx_23060236_dcache_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [TAG_LEN-1:0]    push_tag,
    input  logic [INDEX_LEN-1:0]  push_index,
    input  logic [DATA_LEN-1:0]   push_data,
    input  logic [ADDR_LEN-1:0]   fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_LEN-1:0]   fwd_data,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_LEN-1:0]   awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_LEN-1:0]   wdata,
    output logic [DATA_LEN/8-1:0] wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  drain_done,
    output logic                  wb_err
);

    logic [1:0]          state;
    logic                aw_done;
    logic                w_done;
    logic                full;
    logic                empty;
    logic                push_en;
    logic                b_hs;
    logic                aw_hs;
    logic                w_hs;
    logic [WORD_LEN-1:0] head_addr;
    logic [DATA_LEN-1:0] head_data;

    assign push_ready = !full;
    assign push_en    = push_valid && push_ready;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign b_hs       = bvalid && bready;

    ysyx_23060236_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_en   (push_en),
        .push_addr ({push_tag, push_index}),
        .push_data (push_data),
        .pop_en    (b_hs),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .fwd_addr  (fwd_addr[ADDR_LEN-1:OFFSET_LEN]),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    // Head only moves on the B handshake, so address/data stay stable while valids are up.
    assign awvalid    = (state == WB_SEND) && !aw_done;
    assign wvalid     = (state == WB_SEND) && !w_done;
    assign bready     = state == WB_RESP;
    assign awaddr     = {head_addr, {OFFSET_LEN{1'b0}}};
    assign wdata      = head_data;
    assign wstrb      = '1;
    assign drain_done = empty && (state == WB_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= WB_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (!empty) begin
                        state   <= WB_SEND;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WB_SEND: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WB_RESP;
                end
                WB_RESP: begin
                    if (bvalid) state <= WB_IDLE;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

`ifdef YSYX_23060236_WBUF_ERR_EN
    logic err_q;
    logic unused_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (b_hs && resp_is_err(bresp)) begin
            err_q <= 1'b1;
        end
    end

    assign wb_err      = err_q;
    assign unused_bits = ^fwd_addr[OFFSET_LEN-1:0];
`else
    logic unused_bits;

    assign wb_err      = 1'b0;
    assign unused_bits = ^{fwd_addr[OFFSET_LEN-1:0], bresp};
`endif

endmodule

// File: tb/tb_ysyx_23060236_dcache_wbuf.sv
// Self-checking bench for the dcache write-back buffer against a queue-based reference model.
module tb_ysyx_23060236_dcache_wbuf;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [25:0] push_tag;
    logic [3:0]  push_index;
    logic [31:0] push_data;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        drain_done;
    logic        wb_err;

    entry_t      model_q[$];
    entry_t      exp_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  strb_log[$];
    logic [31:0] cur_addr;
    int          aw_cnt, w_cnt, b_cnt;
    int          total, bad;

    ysyx_23060236_dcache_wbuf #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_tag   (push_tag),
        .push_index (push_index),
        .push_data  (push_data),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .drain_done (drain_done),
        .wb_err     (wb_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_push(input logic [31:0] a, input logic [31:0] d);
        cur_addr   = a;
        push_tag   = a[31:6];
        push_index = a[5:2];
        push_data  = d;
        push_valid = 1'b1;
    endtask

    // One clock: record handshakes happening at the coming edge and advance the model.
    task automatic tick();
        bit     acc;
        entry_t e;
        #1;
        acc = push_valid && !reset && (model_q.size() < DEPTH);
        if (!reset) begin
            if (awvalid && awready) begin aw_log.push_back(awaddr); aw_cnt++; end
            if (wvalid && wready) begin w_log.push_back(wdata); strb_log.push_back(wstrb); w_cnt++; end
            if (bvalid && bready) begin
                b_cnt++;
                if (model_q.size() > 0) model_q.delete(0);
            end
        end
        if (acc) begin
            e.addr = cur_addr & 32'hFFFF_FFFC;
            e.data = push_data;
            model_q.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic void model_fwd(input logic [31:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if ((model_q[i].addr >> 2) == (a >> 2)) begin
                hit = 1'b1;
                d   = model_q[i].data;
                break;
            end
        end
    endfunction

    task automatic drain_all(output bit timed_out);
        int n = 0;
        push_valid = 1'b0;
        awready    = 1'b1;
        wready     = 1'b1;
        bvalid     = 1'b1;
        while ((model_q.size() != 0 || !drain_done) && n < 200) begin
            tick();
            n++;
        end
        bvalid    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        timed_out = n >= 200;
    endtask

    task automatic clear_logs();
        aw_log.delete();
        w_log.delete();
        strb_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        fwd_addr = 32'h0;
        #1;
        total++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            bad++; $display("FAIL reset_valids: got %b want 000", {awvalid, wvalid, bready});
        end
        total++;
        if ({push_ready, drain_done} !== 2'b11) begin
            bad++; $display("FAIL reset_ready_done: got %b want 11", {push_ready, drain_done});
        end
        total++;
        if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
        total++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
            bad++; $display("FAIL reset_fwd: got hit=%b data=%h want 0/0", fwd_hit, fwd_data);
        end
    endtask

    task automatic test_single();
        logic [31:0] a;
        a = (32'h0012_3456 << 6) | (32'h3 << 2);
        set_push(a, 32'hDEAD_BEEF);
        tick();
        push_valid = 1'b0;
        fwd_addr   = a | 32'h1;
        #1;
        total++;
        if (drain_done !== 1'b0 || awvalid !== 1'b0) begin
            bad++; $display("FAIL single_idle: got done=%b awvalid=%b want 0/0", drain_done, awvalid);
        end
        total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_fwd: got hit=%b data=%h want 1/deadbeef", fwd_hit, fwd_data);
        end
        tick();
        total++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== a) begin
            bad++; $display("FAIL single_send: got v=%b awaddr=%h want 11/%h", {awvalid, wvalid}, awaddr, a);
        end
        total++;
        if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
            bad++; $display("FAIL single_wdata: got %h/%h want deadbeef/f", wdata, wstrb);
        end
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        total++;
        if ({awvalid, wvalid, bready, drain_done} !== 4'b0010) begin
            bad++; $display("FAIL single_resp: got %b want 0010", {awvalid, wvalid, bready, drain_done});
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        total++;
        if (drain_done !== 1'b1 || bready !== 1'b0 || fwd_hit !== 1'b0) begin
            bad++; $display("FAIL single_done: got done=%b bready=%b hit=%b want 1/0/0", drain_done, bready, fwd_hit);
        end
        clear_logs();
    endtask

    task automatic test_full();
        bit to;
        bit accepted = 1'b0;
        int b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(32'h9000_0000 + 32'(i) * 32'h40, $urandom);
            total++;
            if (push_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d: got push_ready=%b want 1", i, push_ready); end
            tick();
        end
        set_push(32'h9000_1000, $urandom);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (push_ready !== 1'b0) begin bad++; $display("FAIL full_held%0d: got push_ready=%b want 0", i, push_ready); end
            tick();
        end
        b0      = b_cnt;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        for (int n = 0; n < 30 && !accepted; n++) begin
            total++;
            if (push_ready !== (model_q.size() < DEPTH)) begin
                bad++; $display("FAIL full_ready: got %b want %b", push_ready, model_q.size() < DEPTH);
            end
            if (model_q.size() < DEPTH) begin
                total++;
                if (b_cnt - b0 != 1) begin bad++; $display("FAIL full_fifth_after_b: got b=%0d want 1", b_cnt - b0); end
                accepted = 1'b1;
            end
            tick();
        end
        push_valid = 1'b0;
        total++;
        if (!accepted) begin bad++; $display("FAIL full_accept: got never accepted want accepted"); end
        drain_all(to);
        total++;
        if (to) begin bad++; $display("FAIL full_drain_timeout: got timeout want drained"); end
        total++;
        if (aw_log.size() != exp_q.size() || w_log.size() != exp_q.size()) begin
            bad++; $display("FAIL full_count: got aw=%0d w=%0d want %0d", aw_log.size(), w_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (aw_log[i] !== exp_q[i].addr || w_log[i] !== exp_q[i].data || strb_log[i] !== 4'hF) begin
                    bad++; $display("FAIL full_order%0d: got %h/%h want %h/%h", i, aw_log[i], w_log[i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        clear_logs();
    endtask

    task automatic test_w_first();
        int a0, w0, b0;
        logic [31:0] a;
        a  = 32'hA000_0124;
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        set_push(a, 32'h1234_5678);
        tick();
        push_valid = 1'b0;
        tick();
        wready = 1'b1;
        tick();
        total++;
        if ({awvalid, wvalid} !== 2'b10) begin bad++; $display("FAIL wfirst_w_taken: got %b want 10", {awvalid, wvalid}); end
        tick();
        tick();
        total++;
        if (awvalid !== 1'b1 || awaddr !== a || bready !== 1'b0) begin
            bad++; $display("FAIL wfirst_aw_hold: got v=%b addr=%h bready=%b want 1/%h/0", awvalid, awaddr, bready, a);
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        total++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin bad++; $display("FAIL wfirst_resp: got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        tick();
        total++;
        if (aw_cnt - a0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
            bad++; $display("FAIL wfirst_once: got aw=%0d w=%0d b=%0d want 1/1/1", aw_cnt - a0, w_cnt - w0, b_cnt - b0);
        end
        total++;
        if (drain_done !== 1'b1 || w_log.size() != 1 || w_log[0] !== 32'h1234_5678) begin
            bad++; $display("FAIL wfirst_data: got done=%b n=%0d want done, one word 12345678", drain_done, w_log.size());
        end
        clear_logs();
    endtask

    task automatic test_fwd();
        logic        eh;
        logic [31:0] ed;
        int          n = 0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        set_push(32'h8000_0010, 32'd1);
        tick();
        set_push(32'h8000_0010, 32'd2);
        tick();
        push_valid = 1'b0;
        fwd_addr   = 32'h8000_0012;
        #1;
        total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin
            bad++; $display("FAIL fwd_youngest: got hit=%b data=%h want 1/2", fwd_hit, fwd_data);
        end
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        while ((model_q.size() != 0 || !drain_done) && n < 40) begin
            tick();
            n++;
            model_fwd(fwd_addr, eh, ed);
            total++;
            if (fwd_hit !== eh || fwd_data !== ed) begin
                bad++; $display("FAIL fwd_track: got hit=%b data=%h want %b/%h", fwd_hit, fwd_data, eh, ed);
            end
        end
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        total++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'h0 || n >= 40) begin
            bad++; $display("FAIL fwd_after_drain: got hit=%b data=%h cycles=%0d want 0/0", fwd_hit, fwd_data, n);
        end
        clear_logs();
    endtask

    task automatic test_push_pop();
        bit to;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b0;
        set_push(32'hB000_0000, 32'h11);
        tick();
        set_push(32'hB000_0040, 32'h22);
        tick();
        push_valid = 1'b0;
        for (int n = 0; n < 10 && !bready; n++) tick();
        total++;
        if (bready !== 1'b1) begin bad++; $display("FAIL pushpop_resp: got bready=%b want 1", bready); end
        set_push(32'hB000_0080, 32'h33);
        bvalid = 1'b1;
        total++;
        if (push_ready !== 1'b1) begin bad++; $display("FAIL pushpop_ready: got %b want 1", push_ready); end
        tick();
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'hB000_0100 + 32'(i) * 32'h40, 32'h44 + 32'(i));
            total++;
            if (push_ready !== (model_q.size() < DEPTH)) begin
                bad++; $display("FAIL pushpop_count%0d: got push_ready=%b want %b", i, push_ready, model_q.size() < DEPTH);
            end
            tick();
        end
        push_valid = 1'b0;
        drain_all(to);
        total++;
        if (to) begin bad++; $display("FAIL pushpop_drain_timeout: got timeout want drained"); end
        total++;
        if (aw_log.size() != exp_q.size() || w_log.size() != exp_q.size()) begin
            bad++; $display("FAIL pushpop_total: got aw=%0d w=%0d want %0d", aw_log.size(), w_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (aw_log[i] !== exp_q[i].addr || w_log[i] !== exp_q[i].data) begin
                    bad++; $display("FAIL pushpop_order%0d: got %h/%h want %h/%h", i, aw_log[i], w_log[i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid();
        awready = 1'b1;
        wready  = 1'b1;
        set_push(32'hC000_0200, 32'h5555_AAAA);
        tick();
        push_valid = 1'b0;
        for (int n = 0; n < 10 && !bready; n++) tick();
        total++;
        if (bready !== 1'b1) begin bad++; $display("FAIL rstmid_resp: got bready=%b want 1", bready); end
        reset = 1'b1;
        tick();
        fwd_addr = 32'hC000_0200;
        #1;
        total++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            bad++; $display("FAIL rstmid_valids: got %b want 000", {awvalid, wvalid, bready});
        end
        total++;
        if ({drain_done, push_ready, fwd_hit} !== 3'b110) begin
            bad++; $display("FAIL rstmid_state: got %b want 110", {drain_done, push_ready, fwd_hit});
        end
        reset   = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        model_q.delete();
        clear_logs();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    endtask

    task automatic test_random();
        bit          to;
        logic        eh;
        logic [31:0] ed;
        logic        aw_hold, w_hold;
        logic [31:0] aw_prev, w_prev;
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        aw_prev = '0;
        w_prev  = '0;
        for (int c = 0; c < 400; c++) begin
            model_fwd(fwd_addr, eh, ed);
            total++;
            if (fwd_hit !== eh || fwd_data !== ed) begin
                bad++; $display("FAIL rand_fwd: got hit=%b data=%h want %b/%h at %h", fwd_hit, fwd_data, eh, ed, fwd_addr);
            end
            total++;
            if (push_ready !== (model_q.size() < DEPTH) || drain_done !== (model_q.size() == 0)) begin
                bad++; $display("FAIL rand_flags: got ready=%b done=%b want %b/%b", push_ready, drain_done,
                                model_q.size() < DEPTH, model_q.size() == 0);
            end
            if (aw_hold) begin
                total++;
                if (awvalid !== 1'b1 || awaddr !== aw_prev) begin
                    bad++; $display("FAIL rand_aw_stable: got v=%b addr=%h want 1/%h", awvalid, awaddr, aw_prev);
                end
            end
            if (w_hold) begin
                total++;
                if (wvalid !== 1'b1 || wdata !== w_prev) begin
                    bad++; $display("FAIL rand_w_stable: got v=%b data=%h want 1/%h", wvalid, wdata, w_prev);
                end
            end
            if ($urandom_range(0, 2) != 0) set_push(32'h8000_0040 + 32'($urandom_range(0, 7)) * 4, $urandom);
            else push_valid = 1'b0;
            fwd_addr = 32'h8000_0040 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            awready  = 1'($urandom_range(0, 1));
            wready   = 1'($urandom_range(0, 1));
            bvalid   = (aw_cnt > b_cnt && w_cnt > b_cnt) ? 1'($urandom_range(0, 1)) : 1'b0;
            aw_hold  = awvalid && !awready;
            w_hold   = wvalid && !wready;
            aw_prev  = awaddr;
            w_prev   = wdata;
            tick();
        end
        drain_all(to);
        total++;
        if (to) begin bad++; $display("FAIL rand_drain_timeout: got timeout want drained"); end
        total++;
        if (aw_log.size() != exp_q.size() || w_log.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_total: got aw=%0d w=%0d want %0d", aw_log.size(), w_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (aw_log[i] !== exp_q[i].addr || w_log[i] !== exp_q[i].data || strb_log[i] !== 4'hF) begin
                    bad++; $display("FAIL rand_order%0d: got %h/%h want %h/%h", i, aw_log[i], w_log[i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        clear_logs();
    endtask

    task automatic test_err();
        bit to;
        bresp = 2'b10;
        set_push(32'hD000_0000, 32'h77);
        tick();
        drain_all(to);
        bresp = 2'b00;
`ifdef YSYX_23060236_WBUF_ERR_EN
        total++;
        if (wb_err !== 1'b1 || to) begin bad++; $display("FAIL err_set: got wb_err=%b want 1", wb_err); end
        set_push(32'hD000_0040, 32'h88);
        tick();
        drain_all(to);
        total++;
        if (wb_err !== 1'b1 || to) begin bad++; $display("FAIL err_sticky: got wb_err=%b want 1", wb_err); end
`else
        total++;
        if (wb_err !== 1'b0 || to) begin bad++; $display("FAIL err_tied: got wb_err=%b want 0", wb_err); end
`endif
        clear_logs();
    endtask

    initial begin
        reset      = 1'b1;
        push_valid = 1'b0;
        push_tag   = '0;
        push_index = '0;
        push_data  = '0;
        fwd_addr   = '0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        cur_addr   = '0;
        total      = 0;
        bad        = 0;
        aw_cnt     = 0;
        w_cnt      = 0;
        b_cnt      = 0;
        @(negedge clock);
        test_reset();
        test_single();
        test_full();
        test_w_first();
        test_fwd();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
